fifo_burst_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It drains an exact number of words per command from the FIFO read port (rd_en / data_out / empty) and presents them on a valid/ready stream, with a last-beat marker and a done pulse. The block absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so it sustains one word per cycle under continuous ready. It sits between a FIFO instance and any stream consumer, such as a DMA or serializer.

---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/fifo_skid_buf.sv | 64 ++++++
 rtl/fifo_burst_reader.sv | 108 ++++++++++
 tb/tb_fifo_burst_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and
// output buffer sizing.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO's registered read latency.
// Entry 0 is always the head; a pop shifts entry 1 forward.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic [OCC_WIDTH-1:0]  occ
);

  logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
  logic                  last_q [SKID_DEPTH];
  logic                  pop_ok;
  logic [OCC_WIDTH-1:0]  keep;

  assign pop_ok = pop && (occ != '0);
  assign keep   = occ - OCC_WIDTH'(pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      // NOTE: the storage is reset too, because the head entry drives m_data
      // directly and must read zero out of reset.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (pop_ok) begin
        data_q[0] <= data_q[1];
        last_q[0] <= last_q[1];
      end
      // A write lands behind whatever survives this cycle's pop.
      if (wr_en) begin
        if (keep == '0) begin
          data_q[0] <= wr_data;
          last_q[0] <= wr_last;
        end else begin
          data_q[1] <= wr_data;
          last_q[1] <= wr_last;
        end
      end
      occ <= occ + OCC_WIDTH'(wr_en) - OCC_WIDTH'(pop_ok);
    end
  end

  assign valid = (occ != '0);
  assign data  = data_q[0];
  assign last  = last_q[0];

  // The issue rule upstream guarantees a write never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !pop_ok && occ == OCC_WIDTH'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains an exact word count per command from a registered-read FIFO and
// presents it as a valid/ready stream with last-beat marker and done pulse.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done,
  output logic                  busy
);

  state_t                 state;
  logic [LEN_WIDTH-1:0]   rem_issue;
  logic [LEN_WIDTH-1:0]   rem_out;
  logic                   inflight;
  logic                   pop;
  logic [OCC_WIDTH-1:0]   occ;

  assign pop = m_valid && m_ready;

  // Only read when the word is guaranteed a buffer slot on arrival.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    fifo_rd_en = 1'b0;
    if (state == ST_RUN && !fifo_empty && rem_issue != '0 &&
        (int'(occ) + int'(inflight) - int'(pop)) < SKID_DEPTH)
      fifo_rd_en = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem_issue <= '0;
      rem_out   <= '0;
      inflight  <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every term reads pre-edge values.
      inflight <= fifo_rd_en;
      if (fifo_rd_en) rem_issue <= rem_issue - 1'b1;
      if (inflight)   rem_out   <= rem_out - 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rem_issue <= cmd_len;
            rem_out   <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (fifo_rd_en && rem_issue == LEN_WIDTH'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .wr_last (rem_out == LEN_WIDTH'(1)),
    .pop     (pop),
    .valid   (m_valid),
    .data    (m_data),
    .last    (m_last),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: a queue-based FIFO model plus a
// burst-level reference of the expected stream, checked every cycle.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .done       (done),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_hist[$];
  int            pend_len[$];
  int            hs_cyc[$];

  int ready_mode = 0;
  int pat = 0;
  int cyc = 0;
  bit burst_active = 0;
  int burst_len = 0, beat = 0, burst_rd = 0;
  int outstanding = 0, exp_idx = 0, done_due = -1;
  int accept_cnt = 0, done_cnt = 0, last_cnt = 0, rd_total = 0;
  int accept_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic rd_s = 1'b0;
  logic ready_s = 1'b0;

  task automatic fail(input string name, input int got, input int exp);
    errors++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    wr_hist.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic issue(input int len);
    pend_len.push_back(len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(pend_len[0]);
  endtask

  // Per-cycle scoreboard against the burst-level reference.
  task automatic monitor();
    logic hs;
    hs      = m_valid && m_ready;
    rd_s    = fifo_rd_en;
    ready_s = cmd_ready;
    checks++; if (busy !== burst_active) fail("busy", int'(busy), int'(burst_active));
    checks++; if (cmd_ready !== !burst_active) fail("cmd_ready", int'(cmd_ready), int'(!burst_active));
    if (fifo_rd_en) begin
      burst_rd++; rd_total++;
      checks++; if (fifo_empty !== 1'b0) fail("rd_en_while_empty", 1, 0);
      checks++; if (burst_rd > burst_len || !burst_active) fail("rd_en_excess", burst_rd, burst_len);
    end
    if (prev_stall) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
        fail("stall_hold", int'(m_data), int'(prev_data));
    end
    if (m_valid === 1'b1) begin
      checks++; if (!burst_active) fail("m_valid_idle", 1, 0);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (hs) begin
      hs_cyc.push_back(cyc);
      checks++;
      if (exp_idx >= wr_hist.size()) fail("m_data_extra", int'(m_data), -1);
      else if (m_data !== wr_hist[exp_idx]) fail("m_data", int'(m_data), int'(wr_hist[exp_idx]));
      checks++; if (m_last !== (beat == burst_len - 1)) fail("m_last", int'(m_last), int'(beat == burst_len - 1));
      if (m_last === 1'b1) last_cnt++;
      exp_idx++; beat++; last_hs_cyc = cyc;
      if (beat == burst_len) done_due = cyc + 1;
    end
    outstanding += int'(fifo_rd_en) - int'(hs);
    checks++; if (outstanding > 2 || outstanding < 0) fail("occupancy", outstanding, 2);
    checks++; if (done !== (cyc == done_due)) fail("done", int'(done), int'(cyc == done_due));
    if (done === 1'b1) begin
      done_cnt++; done_cyc = cyc; burst_active = 0;
      checks++; if (burst_rd != burst_len) fail("rd_count", burst_rd, burst_len);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (cmd_valid && cmd_ready) begin
      accept_cnt++; burst_active = 1; burst_len = int'(cmd_len);
      beat = 0; burst_rd = 0; accept_cyc = cyc; first_valid_cyc = -1;
      hs_cyc.delete();
      if (burst_len == 0) done_due = cyc + 1;
      void'(pend_len.pop_front());
    end
  endtask

  task automatic post_edge();
    if (rd_s && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    pat++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (pat % 3 == 0);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    cmd_valid = (pend_len.size() != 0);
    if (cmd_valid) cmd_len = LW'(pend_len[0]);
    else           cmd_len = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    post_edge();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((burst_active || pend_len.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (burst_active || pend_len.size() != 0) fail({name, "_timeout"}, n, budget);
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; fifo_data = '0;
    fifo_empty = 1'b1; m_ready = 1'b0;
    #1 rst = 1'b1;
    #11;
    checks++; if (cmd_ready !== 1'b1)  fail("rst_cmd_ready", int'(cmd_ready), 1);
    checks++; if (fifo_rd_en !== 1'b0) fail("rst_rd_en", int'(fifo_rd_en), 0);
    checks++; if (m_valid !== 1'b0)    fail("rst_m_valid", int'(m_valid), 0);
    checks++; if (m_data !== '0)       fail("rst_m_data", int'(m_data), 0);
    checks++; if (m_last !== 1'b0)     fail("rst_m_last", int'(m_last), 0);
    checks++; if (done !== 1'b0)       fail("rst_done", int'(done), 0);
    checks++; if (busy !== 1'b0)       fail("rst_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    post_edge();
    repeat (2) cycle();
  endtask

  task automatic test_basic();
    int base_rd, base_done;
    ready_mode = 0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(8'h10 + i));
    base_rd = rd_total; base_done = done_cnt;
    issue(4);
    run_until_idle("basic", 40);
    checks++; if (first_valid_cyc != accept_cyc + 3) fail("basic_latency", first_valid_cyc - accept_cyc, 3);
    checks++; if (hs_cyc.size() != 4) fail("basic_beats", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      checks++; if (hs_cyc[i] != hs_cyc[0] + i) fail("basic_throughput", hs_cyc[i] - hs_cyc[0], i);
    end
    checks++; if (done_cyc != last_hs_cyc + 1) fail("basic_done_time", done_cyc - last_hs_cyc, 1);
    checks++; if (rd_total - base_rd != 4) fail("basic_rd_pulses", rd_total - base_rd, 4);
    checks++; if (done_cnt - base_done != 1) fail("basic_done_cnt", done_cnt - base_done, 1);
  endtask

  task automatic test_backpressure();
    int base_rd, base_done;
    ready_mode = 1; pat = 0;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    base_rd = rd_total; base_done = done_cnt;
    issue(6);
    run_until_idle("backpressure", 80);
    checks++; if (beat != 6) fail("bp_beats", beat, 6);
    checks++; if (rd_total - base_rd != 6) fail("bp_rd_pulses", rd_total - base_rd, 6);
    checks++; if (done_cnt - base_done != 1) fail("bp_done_cnt", done_cnt - base_done, 1);
  endtask

  task automatic test_underrun();
    int base_done, base_last;
    ready_mode = 0;
    for (int i = 0; i < 2; i++) push(DW'($urandom));
    base_done = done_cnt; base_last = last_cnt;
    issue(5);
    repeat (12) cycle();
    checks++; if (beat != 2 || !burst_active) fail("underrun_stall", beat, 2);
    for (int i = 0; i < 3; i++) push(DW'($urandom));
    run_until_idle("underrun", 40);
    checks++; if (beat != 5) fail("underrun_beats", beat, 5);
    checks++; if (done_cnt - base_done != 1) fail("underrun_done_cnt", done_cnt - base_done, 1);
    checks++; if (last_cnt - base_last != 1) fail("underrun_last_cnt", last_cnt - base_last, 1);
  endtask

  task automatic test_zero_len();
    int base_rd;
    ready_mode = 0;
    base_rd = rd_total;
    issue(0);
    run_until_idle("zero_len", 10);
    checks++; if (rd_total != base_rd) fail("zero_rd_pulses", rd_total - base_rd, 0);
    checks++; if (first_valid_cyc != -1) fail("zero_m_valid", first_valid_cyc, -1);
    checks++; if (done_cyc != accept_cyc + 1) fail("zero_done_time", done_cyc - accept_cyc, 1);
    cycle();
    checks++; if (ready_s !== 1'b1) fail("zero_cmd_ready_back", int'(ready_s), 1);
  endtask

  task automatic test_back_to_back();
    int base_acc, base_done, base_last, base_idx;
    ready_mode = 2;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    base_acc = accept_cnt; base_done = done_cnt; base_last = last_cnt; base_idx = exp_idx;
    issue(3);
    issue(2);
    run_until_idle("back_to_back", 100);
    checks++; if (accept_cnt - base_acc != 2) fail("b2b_accepts", accept_cnt - base_acc, 2);
    checks++; if (done_cnt - base_done != 2) fail("b2b_done_cnt", done_cnt - base_done, 2);
    checks++; if (last_cnt - base_last != 2) fail("b2b_last_cnt", last_cnt - base_last, 2);
    checks++; if (exp_idx - base_idx != 5) fail("b2b_words", exp_idx - base_idx, 5);
  endtask

  task automatic test_reset_mid();
    int base_acc, base_done, n;
    ready_mode = 3; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    base_acc = accept_cnt;
    issue(4);
    n = 0;
    while (accept_cnt == base_acc && n < 10) begin cycle(); n++; end
    checks++; if (accept_cnt == base_acc) fail("mid_accept_timeout", n, 10);
    repeat (2) cycle();
    checks++; if (m_valid !== 1'b1 || outstanding != 2) fail("mid_precondition", outstanding, 2);
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1)  fail("mid_cmd_ready", int'(cmd_ready), 1);
    checks++; if (fifo_rd_en !== 1'b0) fail("mid_rd_en", int'(fifo_rd_en), 0);
    checks++; if (m_valid !== 1'b0)    fail("mid_m_valid", int'(m_valid), 0);
    checks++; if (m_data !== '0)       fail("mid_m_data", int'(m_data), 0);
    checks++; if (m_last !== 1'b0)     fail("mid_m_last", int'(m_last), 0);
    checks++; if (done !== 1'b0)       fail("mid_done", int'(done), 0);
    checks++; if (busy !== 1'b0)       fail("mid_busy", int'(busy), 0);
    // Words already popped from the FIFO are lost with the abandoned burst.
    burst_active = 0; outstanding = 0; prev_stall = 0; done_due = -1;
    exp_idx = wr_hist.size() - fifo_q.size();
    pend_len.delete(); cmd_valid = 1'b0; rd_s = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ready_mode = 0; m_ready = 1'b1;
    base_done = done_cnt;
    issue(2);
    run_until_idle("after_reset", 30);
    checks++; if (beat != 2) fail("after_reset_beats", beat, 2);
    checks++; if (done_cnt - base_done != 1) fail("after_reset_done_cnt", done_cnt - base_done, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
